// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-Stream output between NumInputs sources.
// Optional per-input packet counters are compiled in when AXIS_ARB_CNT_EN is defined.
module axis_rr_arbiter #(
  parameter int NumInputs = 4,
  parameter int DataWidth = 16,
  parameter int IdWidth   = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumInputs-1:0]           s_valid_i,
  output logic [NumInputs-1:0]           s_ready_o,
  input  logic [NumInputs*DataWidth-1:0] s_data_i,
  input  logic [NumInputs-1:0]           s_last_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [DataWidth-1:0]           m_data_o,
  output logic                           m_last_o,
  output logic [IdWidth-1:0]             m_id_o
`ifdef AXIS_ARB_CNT_EN
  ,
  output logic [NumInputs*16-1:0]        pkt_cnt_o
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e               state_r, state_s;
  logic [IdWidth-1:0]   grant_r, grant_s;
  logic [IdWidth-1:0]   last_grant_r, last_grant_s;
  logic [IdWidth-1:0]   pick_s;
  logic                 found_s;
  logic                 done_s;

  // Round-robin search starting just after the previous winner, wrapping modulo NumInputs.
  always_comb begin
    logic [IdWidth-1:0] cand_v;
    found_s = 1'b0;
    pick_s  = grant_r;
    cand_v  = '0;
    for (int i = 1; i <= NumInputs; i++) begin
      cand_v = IdWidth'((int'(last_grant_r) + i) % NumInputs);
      if (!found_s && s_valid_i[cand_v]) begin
        found_s = 1'b1;
        pick_s  = cand_v;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Output pass-through of the granted source while a packet is in flight.
  always_comb begin
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    m_id_o    = '0;
    s_ready_o = '0;
    if (state_r == ST_BUSY) begin
      m_valid_o          = s_valid_i[grant_r];
      m_data_o           = s_data_i[int'(grant_r)*DataWidth +: DataWidth];
      m_last_o           = s_last_i[grant_r];
      m_id_o             = grant_r;
      s_ready_o[grant_r] = m_ready_i;
    end else begin
      s_ready_o = '0;
    end
  end

  assign done_s = (state_r == ST_BUSY) & s_valid_i[grant_r] & s_last_i[grant_r] & m_ready_i;

  // Next-state logic: grant is locked from the first beat until the last beat transfers.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_BUSY;
          grant_s = pick_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_s) begin
          state_s      = ST_IDLE;
          last_grant_s = grant_r;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and grant registers; reset gives input 0 first priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= IdWidth'(NumInputs - 1);
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
    end
  end

`ifdef AXIS_ARB_CNT_EN
  logic [15:0] cnt_r [NumInputs];

  // Saturating per-input completed-packet counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumInputs; k++) begin
        cnt_r[k] <= 16'h0000;
      end
    end else if (done_s && (cnt_r[grant_r] != 16'hFFFF)) begin
      cnt_r[grant_r] <= cnt_r[grant_r] + 16'h0001;
    end else begin
      cnt_r[grant_r] <= cnt_r[grant_r];
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    pkt_cnt_o = '0;
    for (int k = 0; k < NumInputs; k++) begin
      pkt_cnt_o[k*16 +: 16] = cnt_r[k];
    end
  end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed and randomized bench for axis_rr_arbiter (4 inputs, 16-bit data).
// Randomized traffic is checked against a packet-level round-robin reference.
module tb_axis_rr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_last;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic [1:0]     m_id;
`ifdef AXIS_ARB_CNT_EN
  logic [N*16-1:0] pkt_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  axis_rr_arbiter #(.NumInputs(N), .DataWidth(W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_id_o    (m_id)
`ifdef AXIS_ARB_CNT_EN
    ,
    .pkt_cnt_o (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_in(input int k, input logic v, input logic [15:0] d, input logic l);
    s_valid[k]       = v;
    s_data[k*W +: W] = d;
    s_last[k]        = l;
  endtask

  task automatic clr_all();
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Random-phase source storage and packet-level reference
  logic [15:0] src_d [N][32];
  logic        src_l [N][32];
  logic        src_f [N][32];
  int          src_n [N];
  int          src_p [N];
  int          npk   [N];
  logic [18:0] exp_q [$];

  initial begin
    logic [15:0] bp_d [3];
    logic        bp_pat [5];
    int          rr_exp, bi, rr_last, cyc, total, c, gp;
    int          rem [N];
    logic        busy_m;
    logic [18:0] e;
    logic [1:0]  eid;

    rst_n   = 1'b0;
    m_ready = 1'b0;
    clr_all();
    step();
    smp();
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    chk("reset_m_id", 32'(m_id), 32'd0);
    step();
    rst_n = 1'b1;

    // Single 3-beat packet on input 2
    m_ready = 1'b1;
    set_in(2, 1'b1, 16'h0011, 1'b0);
    smp();
    chk("single_idle_valid", 32'(m_valid), 32'd0);
    chk("single_idle_ready", 32'(s_ready), 32'd0);
    step();
    for (int b = 0; b < 3; b++) begin
      set_in(2, 1'b1, 16'(16'h0011 * (b + 1)), (b == 2));
      smp();
      chk("single_valid", 32'(m_valid), 32'd1);
      chk("single_data", 32'(m_data), 32'(16'h0011 * (b + 1)));
      chk("single_last", 32'(m_last), 32'(b == 2));
      chk("single_id", 32'(m_id), 32'd2);
      chk("single_ready", 32'(s_ready), 32'b0100);
      step();
    end
    clr_all();
    smp();
    chk("single_back_idle", 32'(m_valid), 32'd0);
    step();

    // Round-robin with 1-beat packets on all inputs
    do_reset();
    for (int k = 0; k < N; k++) set_in(k, 1'b1, 16'(16'h0100 * (k + 1)), 1'b1);
    rr_exp = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("rr_bubble", 32'(m_valid), 32'd0);
      step();
      smp();
      chk("rr_id", 32'(m_id), 32'(rr_exp));
      chk("rr_data", 32'(m_data), 32'(16'h0100 * (rr_exp + 1)));
      chk("rr_last", 32'(m_last), 32'd1);
      step();
      rr_exp = (rr_exp + 1) % N;
    end
    clr_all();

    // Packet lock under contention
    do_reset();
    set_in(1, 1'b1, 16'hA000, 1'b0);
    smp();
    chk("lock_idle", 32'(m_valid), 32'd0);
    step();
    for (int b = 0; b < 4; b++) begin
      set_in(1, 1'b1, 16'(16'hA000 + b), (b == 3));
      if (b >= 1) set_in(0, 1'b1, 16'hB000, 1'b1);
      smp();
      chk("lock_id", 32'(m_id), 32'd1);
      chk("lock_data", 32'(m_data), 32'(16'hA000 + b));
      chk("lock_last", 32'(m_last), 32'(b == 3));
      chk("lock_ready", 32'(s_ready), 32'b0010);
      step();
    end
    set_in(1, 1'b0, 16'h0000, 1'b0);
    smp();
    chk("lock_bubble", 32'(m_valid), 32'd0);
    step();
    smp();
    chk("lock_next_id", 32'(m_id), 32'd0);
    chk("lock_next_data", 32'(m_data), 32'hB000);
    chk("lock_next_ready", 32'(s_ready), 32'b0001);
    step();
    clr_all();

    // Backpressure mid-packet on input 2 (last grant is 0)
    bp_d   = '{16'hC000, 16'hC001, 16'hC002};
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bi = 0;
    m_ready = 1'b1;
    set_in(2, 1'b1, bp_d[0], 1'b0);
    smp();
    chk("bp_idle", 32'(m_valid), 32'd0);
    step();
    for (int c2 = 0; c2 < 5; c2++) begin
      m_ready = bp_pat[c2];
      set_in(2, 1'b1, bp_d[bi], (bi == 2));
      smp();
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_data", 32'(m_data), 32'(bp_d[bi]));
      chk("bp_last", 32'(m_last), 32'(bi == 2));
      chk("bp_ready", 32'(s_ready), 32'({m_ready, 2'b00}));
      step();
      if (bp_pat[c2]) bi++;
    end
    chk("bp_beats", 32'(bi), 32'd3);
    clr_all();
    m_ready = 1'b1;
    smp();
    chk("bp_back_idle", 32'(m_valid), 32'd0);
    step();

    // Reset in the middle of a 5-beat packet on input 3
    set_in(3, 1'b1, 16'hD000, 1'b0);
    step();
    for (int b = 0; b < 2; b++) begin
      set_in(3, 1'b1, 16'(16'hD000 + b), 1'b0);
      smp();
      chk("rst_pkt_id", 32'(m_id), 32'd3);
      chk("rst_pkt_data", 32'(m_data), 32'(16'hD000 + b));
      step();
    end
    set_in(3, 1'b1, 16'hD002, 1'b0);
    m_ready = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    set_in(0, 1'b1, 16'hE000, 1'b1);
    smp();
    chk("rst_mid_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_ready", 32'(s_ready), 32'd0);
    chk("rst_mid_id", 32'(m_id), 32'd0);
    step();
    smp();
    chk("rst_winner_id", 32'(m_id), 32'd0);
    chk("rst_winner_data", 32'(m_data), 32'hE000);
    step();
    set_in(0, 1'b0, 16'h0000, 1'b0);
    smp();
    chk("rst_bubble", 32'(m_valid), 32'd0);
    step();
    smp();
    chk("rst_resume_id", 32'(m_id), 32'd3);
    chk("rst_resume_data", 32'(m_data), 32'hD002);
    clr_all();
    m_ready = 1'b0;

    // Randomized traffic against a packet-level round-robin reference
    do_reset();
`ifdef AXIS_ARB_CNT_EN
    smp();
    chk("cnt_after_reset", 32'(pkt_cnt), 32'd0);
`endif
    total = 0;
    for (int k = 0; k < N; k++) begin
      npk[k]   = $urandom_range(1, 4);
      rem[k]   = npk[k];
      src_n[k] = 0;
      src_p[k] = 0;
      total   += npk[k];
      for (int p = 0; p < npk[k]; p++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          src_d[k][src_n[k]] = 16'($urandom);
          src_l[k][src_n[k]] = (b == len - 1);
          src_f[k][src_n[k]] = (b == 0);
          src_n[k]++;
        end
      end
    end
    rr_last = N - 1;
    for (int k = 0; k < N; k++) rem[k] = npk[k];
    begin
      int gptr [N];
      for (int k = 0; k < N; k++) gptr[k] = 0;
      for (int t = 0; t < total; t++) begin
        c = -1;
        for (int off = 1; off <= N; off++) begin
          if (c < 0 && rem[(rr_last + off) % N] > 0) c = (rr_last + off) % N;
        end
        gp = gptr[c];
        do begin
          exp_q.push_back({2'(c), src_l[c][gp], src_d[c][gp]});
          gp++;
        end while (!src_l[c][gp-1]);
        gptr[c] = gp;
        rem[c]--;
        rr_last = c;
      end
    end

    busy_m = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      for (int k = 0; k < N; k++) begin
        if (src_p[k] < src_n[k]) begin
          set_in(k, src_f[k][src_p[k]] ? 1'b1 : ($urandom_range(0, 3) != 0),
                 src_d[k][src_p[k]], src_l[k][src_p[k]]);
        end else begin
          set_in(k, 1'b0, 16'h0000, 1'b0);
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      smp();
      if (!busy_m) begin
        chk("rnd_idle_valid", 32'(m_valid), 32'd0);
        chk("rnd_idle_ready", 32'(s_ready), 32'd0);
        busy_m = 1'b1;
      end else begin
        e   = exp_q[0];
        eid = e[18:17];
        chk("rnd_id", 32'(m_id), 32'(eid));
        chk("rnd_ready", 32'(s_ready), 32'(4'(m_ready) << eid));
        chk("rnd_valid", 32'(m_valid), 32'(s_valid[eid]));
        if (s_valid[eid]) begin
          chk("rnd_data", 32'(m_data), 32'(e[15:0]));
          chk("rnd_last", 32'(m_last), 32'(e[16]));
          if (m_ready) begin
            void'(exp_q.pop_front());
            if (e[16]) busy_m = 1'b0;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (s_valid[k] && s_ready[k]) src_p[k]++;
      end
      step();
      cyc++;
    end
    chk("rnd_timeout_left", 32'(exp_q.size()), 32'd0);
`ifdef AXIS_ARB_CNT_EN
    smp();
    for (int k = 0; k < N; k++) begin
      chk("cnt_slice", 32'(pkt_cnt[k*16 +: 16]), 32'(npk[k]));
    end
`endif
    clr_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
